// File: rtl/sar_pkg.sv
// Shared definitions for the SAR logic controller: state codes, decision
// encoding and the phase-timer width helper.
package sar_pkg;

    localparam int SAR_NBITS_DEF  = 8;
    localparam int SAR_SAMPLE_DEF = 2;
    localparam int SAR_SETTLE_DEF = 1;

    // Timer width large enough to hold the longer of the two phase lengths.
    function automatic int cnt_width(input int sample_cycles, input int settle_cycles);
        int m;
        m = (sample_cycles > settle_cycles) ? sample_cycles : settle_cycles;
        return $clog2(m + 1);
    endfunction

    localparam int SAR_CNT_W = cnt_width(SAR_SAMPLE_DEF, SAR_SETTLE_DEF);

    typedef logic [2:0] sar_state_t;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SAMPLE  = 3'd1;
    localparam logic [2:0] ST_SETTLE  = 3'd2;
    localparam logic [2:0] ST_COMPARE = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    localparam logic [1:0] DEC_ZERO    = 2'b00;
    localparam logic [1:0] DEC_ONE     = 2'b01;
    localparam logic [1:0] DEC_INVALID = 2'b10;

    // Map the comparator's complementary outputs onto a decision code.
    // Equal outputs mean the comparator did not resolve (or went metastable).
    function automatic logic [1:0] decode_cmp(input logic outp, input logic outn);
        logic [1:0] dec;
        if (outp == outn) begin
            dec = DEC_INVALID;
        end else if (outp) begin
            dec = DEC_ONE;
        end else begin
            dec = DEC_ZERO;
        end
        return dec;
    endfunction

endpackage

// File: rtl/sar_phase_timer.sv
// Loadable down-counter shared by the SAMPLE and SETTLE phases. The expiry
// flag is high whenever the count has reached zero, so loading N-1 gives a
// phase of exactly N cycles.
module sar_phase_timer
    import sar_pkg::*;
#(
    parameter int CNT_W = SAR_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_expired
);

    logic [CNT_W-1:0] r_count;

    // Load on request, otherwise count down and park at zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_expired = (r_count == '0);

endmodule

// File: rtl/sar_logic_ctrl.sv
// Successive-approximation controller sitting behind the dynamic comparator.
// Drives the comparator clock pair, the DAC trial code and the S/H track
// switch, and publishes each finished conversion with a one-cycle VALID.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for START, comparator held in precharge
// SAMPLE  | TRACK high for SAMPLE_CYCLES, input being acquired
// SETTLE  | DAC trial code settling for SETTLE_CYCLES before a compare
// COMPARE | one-cycle comparator evaluate; decision taken on exit edge
// DONE    | result published (VALID), may restart directly into SAMPLE
module sar_logic_ctrl
    import sar_pkg::*;
#(
    parameter int NBITS         = SAR_NBITS_DEF,
    parameter int SAMPLE_CYCLES = SAR_SAMPLE_DEF,
    parameter int SETTLE_CYCLES = SAR_SETTLE_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_cmp_outp,
    input  logic             i_cmp_outn,
    output logic             o_cmp_clk,
    output logic             o_cmp_clkbar,
    output logic             o_track,
    output logic [NBITS-1:0] o_dac_code,
    output logic [NBITS-1:0] o_data,
    output logic             o_valid,
    output logic             o_busy,
    output logic             o_dec_err
);

    localparam int CNT_W = cnt_width(SAMPLE_CYCLES, SETTLE_CYCLES);
    localparam int KW    = (NBITS > 1) ? $clog2(NBITS) : 1;

    localparam logic [CNT_W-1:0] SAMPLE_LOAD = CNT_W'(SAMPLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [NBITS-1:0] DAC_MSB     = {1'b1, {(NBITS-1){1'b0}}};
    localparam logic [NBITS-1:0] DAC_ONE     = {{(NBITS-1){1'b0}}, 1'b1};
    localparam logic [KW-1:0]    K_TOP       = KW'(NBITS - 1);

    sar_state_t       r_state;
    logic [NBITS-1:0] r_dac;
    logic [KW-1:0]    r_k;
    logic             r_err;
    logic             r_track;
    logic             r_busy;
    logic             r_cmp_clk;
    logic             r_cmp_clkbar;
    logic [NBITS-1:0] r_data;
    logic             r_valid;
    logic             r_dec_err;

    sar_state_t       w_state_nxt;
    logic [NBITS-1:0] w_dac_nxt;
    logic [KW-1:0]    w_k_nxt;
    logic             w_err_nxt;
    logic             w_track_nxt;
    logic             w_busy_nxt;
    logic             w_cmp_clk_nxt;
    logic             w_done;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_expired;
    logic [1:0]       w_dec;
    logic [NBITS-1:0] w_bit_k;
    logic [NBITS-1:0] w_dac_decided;

    sar_phase_timer #(
        .CNT_W (CNT_W)
    ) u_phase_timer (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_expired  (w_expired)
    );

    // Decision for the bit under test and the code it leaves behind.
    always_comb begin
        w_dec         = decode_cmp(i_cmp_outp, i_cmp_outn);
        w_bit_k       = DAC_ONE << r_k;
        w_dac_decided = (w_dec == DEC_ONE) ? r_dac : (r_dac & ~w_bit_k);
    end

    // Next-state and next-output logic for the conversion sequence.
    always_comb begin
        w_state_nxt = r_state;
        w_dac_nxt   = r_dac;
        w_k_nxt     = r_k;
        w_err_nxt   = r_err;
        w_track_nxt = r_track;
        w_busy_nxt  = r_busy;
        w_done      = 1'b0;
        w_load      = 1'b0;
        w_load_val  = SETTLE_LOAD;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    w_state_nxt = ST_SAMPLE;
                    w_load      = 1'b1;
                    w_load_val  = SAMPLE_LOAD;
                    w_dac_nxt   = DAC_MSB;
                    w_k_nxt     = K_TOP;
                    w_err_nxt   = 1'b0;
                    w_track_nxt = 1'b1;
                    w_busy_nxt  = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SAMPLE: begin
                if (w_expired) begin
                    w_state_nxt = ST_SETTLE;
                    w_load      = 1'b1;
                    w_load_val  = SETTLE_LOAD;
                    w_track_nxt = 1'b0;
                end
            end
            ST_SETTLE: begin
                if (w_expired) begin
                    w_state_nxt = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                if (w_dec == DEC_INVALID) begin
                    w_err_nxt = 1'b1;
                end
                if (r_k != '0) begin
                    w_dac_nxt   = w_dac_decided | (w_bit_k >> 1);
                    w_k_nxt     = r_k - KW'(1);
                    w_state_nxt = ST_SETTLE;
                    w_load      = 1'b1;
                    w_load_val  = SETTLE_LOAD;
                end else begin
                    w_dac_nxt   = w_dac_decided;
                    w_state_nxt = ST_DONE;
                    w_busy_nxt  = 1'b0;
                    w_done      = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
                w_track_nxt = 1'b0;
            end
        endcase

        // Evaluate only while in COMPARE; both clock phases come from this one bit.
        w_cmp_clk_nxt = (w_state_nxt == ST_COMPARE);
    end

    // FSM, SAR register and comparator clock pair.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_dac        <= '0;
            r_k          <= '0;
            r_err        <= 1'b0;
            r_track      <= 1'b0;
            r_busy       <= 1'b0;
            r_cmp_clk    <= 1'b0;
            r_cmp_clkbar <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_dac        <= w_dac_nxt;
            r_k          <= w_k_nxt;
            r_err        <= w_err_nxt;
            r_track      <= w_track_nxt;
            r_busy       <= w_busy_nxt;
            r_cmp_clk    <= w_cmp_clk_nxt;
            r_cmp_clkbar <= ~w_cmp_clk_nxt;
        end
    end

    // Result registers: DATA and DEC_ERR only move together with VALID.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data    <= '0;
            r_dec_err <= 1'b0;
            r_valid   <= 1'b0;
        end else begin
            r_valid <= w_done;
            if (w_done) begin
                r_data    <= w_dac_nxt;
                r_dec_err <= w_err_nxt;
            end
        end
    end

    assign o_cmp_clk    = r_cmp_clk;
    assign o_cmp_clkbar = r_cmp_clkbar;
    assign o_track      = r_track;
    assign o_dac_code   = r_dac;
    assign o_data       = r_data;
    assign o_valid      = r_valid;
    assign o_busy       = r_busy;
    assign o_dec_err    = r_dec_err;

endmodule

// File: tb/tb_sar_logic_ctrl.sv
// Scoreboard bench for sar_logic_ctrl: a behavioural comparator answers each
// evaluate pulse from the bench's analog input value, the driver pushes the
// expected trial codes and result for every accepted START, and a monitor
// pops and compares whenever the DUT pulses the comparator clock or VALID.
module tb_sar_logic_ctrl;

    localparam int NB  = 8;
    localparam int SC  = 2;
    localparam int STC = 1;
    localparam int LAT = SC + NB * (STC + 1);

    typedef struct {
        logic [7:0] data;
        logic       err;
        int         vcyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       start = 1'b0;
    logic       cmp_outp;
    logic       cmp_outn;
    logic       cmp_clk;
    logic       cmp_clkbar;
    logic       track;
    logic [7:0] dac_code;
    logic [7:0] data;
    logic       valid;
    logic       busy;
    logic       dec_err;

    logic [7:0] vin = 8'h00;
    int         fault_bit = -1;
    int         pulse_idx = 0;
    int         cyc = 0;
    int         n_pass = 0;
    int         n_total = 0;

    exp_t       exp_q[$];
    logic [7:0] trial_q[$];

    always #5 clk = ~clk;

    sar_logic_ctrl #(
        .NBITS         (NB),
        .SAMPLE_CYCLES (SC),
        .SETTLE_CYCLES (STC)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rstn),
        .i_start      (start),
        .i_cmp_outp   (cmp_outp),
        .i_cmp_outn   (cmp_outn),
        .o_cmp_clk    (cmp_clk),
        .o_cmp_clkbar (cmp_clkbar),
        .o_track      (track),
        .o_dac_code   (dac_code),
        .o_data       (data),
        .o_valid      (valid),
        .o_busy       (busy),
        .o_dec_err    (dec_err)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Index of the current evaluate pulse within a conversion (0 = MSB).
    always @(posedge clk or negedge rstn) begin
        if (!rstn)        pulse_idx <= 0;
        else if (track)   pulse_idx <= 0;
        else if (cmp_clk) pulse_idx <= pulse_idx + 1;
    end

    // Comparator: Vp = vin against Vn = DAC code; outputs precharged low.
    always_comb begin
        cmp_outp = 1'b0;
        cmp_outn = 1'b0;
        if (cmp_clk) begin
            if (pulse_idx == NB - 1 - fault_bit) begin
                cmp_outp = 1'b1;
                cmp_outn = 1'b1;
            end else if (vin >= dac_code) begin
                cmp_outp = 1'b1;
            end else begin
                cmp_outn = 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
    endtask

    // Reference: binary search with "keep bit if Vp >= trial"; a forced
    // unresolved decision clears that bit and flags the conversion.
    task automatic push_expect(input logic [7:0] v, input int fb, input int vcyc);
        logic [7:0] code;
        logic [7:0] trial;
        logic       err;
        exp_t       e;
        code = 8'h00;
        err  = 1'b0;
        for (int k = NB - 1; k >= 0; k--) begin
            trial = code | (8'h01 << k);
            trial_q.push_back(trial);
            if (k == fb) err = 1'b1;
            else if (v >= trial) code = trial;
        end
        e.data = code;
        e.err  = err;
        e.vcyc = vcyc;
        exp_q.push_back(e);
    endtask

    // Called just after a falling edge with the DUT idle; next rising edge is E0.
    task automatic conv(input logic [7:0] v, input int fb);
        vin       = v;
        fault_bit = fb;
        start     = 1'b1;
        push_expect(v, fb, cyc + 1 + LAT);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            chk("conv_timeout", exp_q.size(), 0);
            exp_q.delete();
            trial_q.delete();
        end
        @(negedge clk);
        fault_bit = -1;
    endtask

    // Monitor: per-cycle clock-pair invariants, trial codes, and results.
    initial begin : monitor
        logic       prev_clk;
        logic [7:0] prev_dac;
        int         npulse;
        exp_t       e;
        prev_clk = 1'b0;
        prev_dac = 8'h00;
        npulse   = 0;
        forever begin
            @(negedge clk);
            chk("clkbar_complement", 32'(cmp_clkbar ^ cmp_clk), 1);
            if (!rstn) begin
                npulse   = 0;
                prev_clk = 1'b0;
            end else begin
                if (cmp_clk) begin
                    chk("cmp_clk_single", prev_clk, 0);
                    chk("cmp_clk_no_track", track, 0);
                    chk("dac_stable", dac_code, prev_dac);
                    if (trial_q.size() == 0) chk("unexpected_cmp_clk", 1, 0);
                    else chk("dac_trial", dac_code, trial_q.pop_front());
                    npulse++;
                end
                if (valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_valid", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("data", data, e.data);
                        chk("dec_err", dec_err, e.err);
                        chk("valid_cycle", cyc, e.vcyc);
                        chk("cmp_pulses", npulse, NB);
                        chk("busy_at_valid", busy, 0);
                    end
                    npulse = 0;
                end
                prev_clk = cmp_clk;
            end
            prev_dac = dac_code;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : driver
        int t;
        int v;
        int fb;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cmp_clk", cmp_clk, 0);
        chk("rst_cmp_clkbar", cmp_clkbar, 1);
        chk("rst_track", track, 0);
        chk("rst_dac", dac_code, 0);
        chk("rst_data", data, 0);
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dec_err", dec_err, 0);
        rstn = 1'b1;
        @(negedge clk);

        // Directed 0xA5
        conv(8'hA5, -1);
        chk("busy_after_start", busy, 1);
        chk("track_after_start", track, 1);
        wait_done();
        chk("data_held", data, 8'hA5);

        // Back-to-back 0x00 then 0xFF with START held high
        vin   = 8'h00;
        start = 1'b1;
        push_expect(8'h00, -1, cyc + 1 + LAT);
        push_expect(8'hFF, -1, cyc + 1 + LAT + 1 + LAT);
        @(negedge clk);
        t = 0;
        while (!valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("b2b_first_valid_seen", valid, 1);
        vin = 8'hFF;
        @(negedge clk);
        chk("b2b_busy_next", busy, 1);
        chk("b2b_track_next", track, 1);
        start = 1'b0;
        wait_done();

        // START re-pulsed at E0+5 is ignored
        conv(8'h3C, -1);
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (25) @(negedge clk);
        chk("ignored_start_idle", busy, 0);

        // Unresolved decision on bit 4, then a clean conversion
        conv(8'hFF, 4);
        wait_done();
        chk("fault_dec_err_held", dec_err, 1);
        conv(8'h33, -1);
        wait_done();
        chk("clean_dec_err", dec_err, 0);

        // Asynchronous reset in the middle of COMPARE
        conv(8'h77, -1);
        t = 0;
        while (!cmp_clk && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("reach_compare", cmp_clk, 1);
        #2 rstn = 1'b0;
        #1;
        chk("arst_cmp_clk", cmp_clk, 0);
        chk("arst_cmp_clkbar", cmp_clkbar, 1);
        chk("arst_track", track, 0);
        chk("arst_dac", dac_code, 0);
        chk("arst_data", data, 0);
        chk("arst_valid", valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_dec_err", dec_err, 0);
        exp_q.delete();
        trial_q.delete();
        fault_bit = -1;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        conv(8'h5A, -1);
        wait_done();

        // Randomized conversions, occasional faults and ignored STARTs
        for (int i = 0; i < 24; i++) begin
            v  = int'($urandom_range(0, 255));
            fb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NB - 1)) : -1;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            conv(v[7:0], fb);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(0, 14)) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            wait_done();
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("trials_empty", trial_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sar_logic_ctrl.md
Name: sar_logic_ctrl

Overview:
- Digital successive-approximation controller directly downstream of the dynamic comparator.
- Generates the comparator's complementary clocks, consumes its Outp/Outn decision pair, drives the capacitive/R-2R DAC code and produces an N-bit conversion result.
- Sits between the analog comparator macro and the user-project digital wrapper (Wishbone/logic-analyzer side).

Parameters:
- NBITS, 8, resolution; also the width of DAC_CODE and DATA.
- SAMPLE_CYCLES, 2, clock cycles TRACK is held high. Must be ≥1.
- SETTLE_CYCLES, 1, DAC settling cycles before each compare. Must be ≥1.

Ports:
- CLK  in  1  system clock; all state on rising edge.
- RSTN  in  1  asynchronous active-low reset.
- START  in  1  conversion request; level-sampled.
- CMP_OUTP  in  1  comparator Outp (high: Vp > Vn).
- CMP_OUTN  in  1  comparator Outn.
- CMP_CLK  out  1  comparator CLK. Registered. High means evaluate.
- CMP_CLKBAR  out  1  always the exact complement of CMP_CLK. Registered from the same next-state value, never a combinational inverter.
- TRACK  out  1  sample switch enable for the input S/H.
- DAC_CODE  out  NBITS  trial code to the DAC, which drives comparator Vn.
- DATA  out  NBITS  last completed result. Held until the next result.
- VALID  out  1  one-cycle pulse when DATA updates.
- BUSY  out  1  high from START acceptance until DONE.
- DEC_ERR  out  1  invalid comparator decision seen in the last conversion. Updates with DATA.

Behaviour:
- Reset (async, RSTN low), all outputs forced immediately:
  - state=IDLE, CMP_CLK=0, CMP_CLKBAR=1, TRACK=0.
  - DAC_CODE=0, DATA=0, VALID=0, BUSY=0, DEC_ERR=0.
  - Reset mid-conversion abandons it with no VALID. CMP_CLK falls asynchronously, which returns the comparator to its precharge phase.
- States: IDLE, SAMPLE, SETTLE, COMPARE, DONE.
- IDLE: START=1 at edge E0 → SAMPLE. On entry:
  - BUSY=1, TRACK=1.
  - DAC_CODE = 1<<(NBITS-1); bit index k = NBITS-1; error flag cleared.
- SAMPLE: held for SAMPLE_CYCLES cycles, then → SETTLE with TRACK=0.
- SETTLE: counts SETTLE_CYCLES cycles, then → COMPARE with CMP_CLK=1, CMP_CLKBAR=0.
- COMPARE: lasts exactly one cycle. At the exiting edge:
  - CMP_OUTP and CMP_OUTN are captured.
  - CMP_CLK returns to 0 on the same edge (precharge). The comparator output hold time is covered by the clock-to-Q delay.
- Decision rule at that edge:
  - OUTP=1, OUTN=0: bit k kept at 1.
  - OUTP=0, OUTN=1: bit k cleared.
  - OUTP==OUTN (00 or 11, unresolved or metastable): bit k cleared and the internal error flag set (sticky for this conversion).
- After the decision:
  - If k>0: set bit k-1, decrement k, → SETTLE.
  - If k=0: → DONE.
- DONE (one cycle):
  - DATA = final DAC_CODE, DEC_ERR = error flag, VALID=1, BUSY=0.
  - Next state is IDLE; if START=1 at this edge, go straight to SAMPLE instead (back-to-back conversions).
- Latency: VALID is high in the cycle after edge E0 + SAMPLE_CYCLES + NBITS*(SETTLE_CYCLES+1). Defaults: E0+18.
- START while BUSY (in SAMPLE, SETTLE or COMPARE) is ignored. No queuing.
- DAC_CODE is stable throughout SETTLE and COMPARE. It changes only on the edge leaving COMPARE or SAMPLE entry.
- CMP_CLK is never high for more than one consecutive cycle and never high outside COMPARE.

Decomposition:
- Shared package sar_pkg:
  - State enum (IDLE, SAMPLE, SETTLE, COMPARE, DONE).
  - Localparam for counter width, clog2 of max(SAMPLE_CYCLES, SETTLE_CYCLES)+1.
  - Decision encoding constants (DEC_ONE, DEC_ZERO, DEC_INVALID).
- One natural sub-module: sar_phase_timer. A loadable down-counter with an expiry flag, shared by SAMPLE and SETTLE.
- The FSM, SAR register and output registers stay in sar_logic_ctrl.

Test Plan:
- Behavioral comparator model, input 0xA5 (compare Vp=0xA5 against DAC_CODE), START pulse → DAC_CODE sequence 0x80,0xC0,0xA0,0xB0,0xA8,0xA4,0xA6,0xA5. DATA=0xA5, VALID one cycle at E0+18, DEC_ERR=0, exactly 8 CMP_CLK pulses.
- Inputs 0x00 and 0xFF, including back-to-back START held high → DATA=0x00 then 0xFF. Second BUSY starts the cycle after the first VALID, with no IDLE cycle.
- START re-pulsed at E0+5 during conversion of 0x3C → ignored; single VALID with DATA=0x3C.
- Comparator model forced to OUTP=OUTN=1 on bit 4 decision, input 0xFF → DATA=0xEF, DEC_ERR=1. Next clean conversion clears DEC_ERR to 0.
- RSTN low asynchronously mid-COMPARE (CMP_CLK=1) → CMP_CLK=0 and CMP_CLKBAR=1 before the next edge, all outputs at reset values, no VALID. After release, a new START converts 0x5A correctly.
- Every cycle of every test → assert CMP_CLKBAR == ~CMP_CLK, CMP_CLK high only in COMPARE, DAC_CODE stable while CMP_CLK=1.
